// File: rtl/sample_rr_collector_if.sv
// sample_rr_collector_if: per-channel sample inputs, merged output stage and status of the collector.
interface sample_rr_collector_if #(
  parameter int NCH = 4,
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
);
  logic             in_valid [0:NCH-1];
  logic [WIDTH-1:0] in_data  [0:NCH-1];
  logic             in_ready [0:NCH-1];
  logic             enable;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_chan;
  logic [LW-1:0]    level    [0:NCH-1];
  logic             ovf      [0:NCH-1];
  logic             ovf_clr  [0:NCH-1];
  modport master (
    output in_valid, in_data, enable, out_ready, ovf_clr,
    input  in_ready, out_valid, out_data, out_chan, level, ovf
  );
  modport slave (
    input  in_valid, in_data, enable, out_ready, ovf_clr,
    output in_ready, out_valid, out_data, out_chan, level, ovf
  );
endinterface

// File: rtl/sample_rr_collector.sv
// sample_rr_collector: per-channel FIFOs merged round-robin onto one registered, channel-tagged output.
module sample_rr_collector #(
  parameter int NCH = 4,
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic clk,
  input logic rst,
  sample_rr_collector_if.slave bus
);
  logic [WIDTH-1:0] r_mem [NCH][DEPTH];
  logic [PW-1:0]    r_wp [NCH];
  logic [PW-1:0]    r_rp [NCH];
  logic [LW-1:0]    r_level [NCH];
  logic             r_ovf [NCH];
  logic [CW-1:0]    r_last;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_chan;
  logic             w_in_ready [NCH];
  logic             w_push [NCH];
  logic             w_pop_ch [NCH];
  logic             w_free;
  logic             w_any;
  logic             w_pop;
  logic [CW-1:0]    w_gch;
  logic [CW-1:0]    w_idx;
  // Scan from the farthest candidate to the nearest so the nearest non-empty channel wins.
  always_comb begin
    w_free = !r_out_valid || bus.out_ready;
    w_any = 1'b0;
    w_gch = r_last;
    w_idx = r_last;
    for (int k = NCH; k >= 1; k--) begin
      w_idx = CW'((int'(r_last) + k) % NCH);
      w_any = w_any || (r_level[w_idx] != '0);
      w_gch = (r_level[w_idx] != '0) ? w_idx : w_gch;
    end
    w_pop = w_free && bus.enable && w_any;
    for (int i = 0; i < NCH; i++) begin
      w_in_ready[i] = !rst && (r_level[i] != LW'(DEPTH));
      w_push[i] = bus.in_valid[i] && w_in_ready[i];
      w_pop_ch[i] = w_pop && (w_gch == CW'(i));
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (w_push[i]) r_mem[i][r_wp[i]] <= bus.in_data[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_wp[i] <= '0;
        r_rp[i] <= '0;
        r_level[i] <= '0;
        r_ovf[i] <= 1'b0;
      end
      r_last <= CW'(NCH - 1);
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_chan <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_push[i]) r_wp[i] <= (r_wp[i] == PW'(DEPTH - 1)) ? '0 : r_wp[i] + 1'b1;
        if (w_pop_ch[i]) r_rp[i] <= (r_rp[i] == PW'(DEPTH - 1)) ? '0 : r_rp[i] + 1'b1;
        r_level[i] <= r_level[i] + LW'(w_push[i]) - LW'(w_pop_ch[i]);
        r_ovf[i] <= (bus.in_valid[i] && !w_in_ready[i]) || (r_ovf[i] && !bus.ovf_clr[i]);
      end
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data <= r_mem[w_gch][r_rp[w_gch]];
        r_out_chan <= w_gch;
        r_last <= w_gch;
      end else if (w_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end
  assign bus.in_ready = w_in_ready;
  assign bus.level = r_level;
  assign bus.ovf = r_ovf;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.out_chan = r_out_chan;
endmodule

// File: tb/tb_sample_rr_collector.sv
// tb_sample_rr_collector: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_sample_rr_collector;
  localparam int NCH = 4, WIDTH = 4, DEPTH = 2;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] mq [NCH][$];
  logic m_ov;
  logic [3:0] m_od;
  int m_oc;
  int m_last;
  logic [NCH-1:0] m_ovf;
  typedef struct {
    logic r;
    logic [3:0] v;
    logic [15:0] d;
    logic en;
    logic ordy;
    logic [3:0] clr;
    logic ev;
    logic [3:0] ed;
    logic [1:0] ec;
    logic [7:0] lvl;
  } vec_t;
  vec_t tbl [9];
  always #5 clk = ~clk;
  sample_rr_collector_if #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  sample_rr_collector #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] d, input logic en,
                       input logic ordy, input logic [3:0] clr);
    rst = r;
    bus.enable = en;
    bus.out_ready = ordy;
    for (int i = 0; i < NCH; i++) begin
      bus.in_valid[i] = v[i];
      bus.in_data[i] = d[i*4+:4];
      bus.ovf_clr[i] = clr[i];
    end
  endtask
  task automatic model_update();
    bit rdy [NCH];
    bit free, got;
    int c;
    if (rst) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_ov = 1'b0;
      m_od = '0;
      m_oc = 0;
      m_ovf = '0;
      m_last = NCH - 1;
    end else begin
      for (int i = 0; i < NCH; i++) rdy[i] = mq[i].size() != DEPTH;
      free = !m_ov || bus.out_ready;
      got = 0;
      if (free && bus.enable)
        for (int k = 1; k <= NCH; k++) begin
          c = (m_last + k) % NCH;
          if (!got && mq[c].size() > 0) begin
            got = 1;
            m_od = mq[c].pop_front();
            m_oc = c;
            m_last = c;
            m_ov = 1'b1;
          end
        end
      if (free && !got) m_ov = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (bus.in_valid[i] && rdy[i]) mq[i].push_back(bus.in_data[i]);
        if (bus.in_valid[i] && !rdy[i]) m_ovf[i] = 1'b1;
        else if (bus.ovf_clr[i]) m_ovf[i] = 1'b0;
      end
    end
  endtask
  task automatic step();
    #2;
    for (int i = 0; i < NCH; i++)
      chk($sformatf("in_ready[%0d]", i), 32'(bus.in_ready[i]), 32'(!rst && mq[i].size() != DEPTH));
    model_update();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(bus.out_data), 32'(m_od));
      chk("out_chan", 32'(bus.out_chan), 32'(m_oc));
    end
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("level[%0d]", i), 32'(bus.level[i]), 32'(mq[i].size()));
      chk($sformatf("ovf[%0d]", i), 32'(bus.ovf[i]), 32'(m_ovf[i]));
    end
  endtask
  initial begin
    tbl[0] = '{1'b0, 4'b0100, 16'h0500, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 8'h10};
    tbl[1] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b1, 4'h5, 2'd2, 8'h00};
    tbl[2] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 8'h00};
    tbl[3] = '{1'b0, 4'b1111, 16'h4321, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 8'h55};
    tbl[4] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b1, 4'h1, 2'd0, 8'h54};
    tbl[5] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b1, 4'h2, 2'd1, 8'h50};
    tbl[6] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b1, 4'h3, 2'd2, 8'h40};
    tbl[7] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b1, 4'h4, 2'd3, 8'h00};
    tbl[8] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 8'h00};
    for (int i = 0; i < NCH; i++) mq[i].delete();
    m_ov = 1'b0;
    m_od = '0;
    m_oc = 0;
    m_ovf = '0;
    m_last = NCH - 1;
    drive(1'b1, 4'h0, 16'h0, 1'b1, 1'b1, 4'h0);
    step();
    step();
    chk("reset out_data", 32'(bus.out_data), 32'h0);
    chk("reset out_chan", 32'(bus.out_chan), 32'h0);
    for (int r = 0; r < 9; r++) begin
      drive(tbl[r].r, tbl[r].v, tbl[r].d, tbl[r].en, tbl[r].ordy, tbl[r].clr);
      step();
      chk($sformatf("tbl%0d out_valid", r), 32'(bus.out_valid), 32'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk($sformatf("tbl%0d out_data", r), 32'(bus.out_data), 32'(tbl[r].ed));
        chk($sformatf("tbl%0d out_chan", r), 32'(bus.out_chan), 32'(tbl[r].ec));
      end
      chk($sformatf("tbl%0d levels", r), 32'({bus.level[3], bus.level[2], bus.level[1], bus.level[0]}), 32'(tbl[r].lvl));
    end
    drive(1'b1, 4'h0, 16'h0, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b0, 4'b0010, 16'h0070, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b0, 4'b0010, 16'h0080, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b0, 4'b0010, 16'h0090, 1'b1, 1'b0, 4'h0);
    step();
    chk("full in_ready[1]", 32'(bus.in_ready[1]), 32'h0);
    chk("full level[1]", 32'(bus.level[1]), 32'h2);
    chk("full out_data", 32'(bus.out_data), 32'h7);
    drive(1'b0, 4'b0010, 16'h00A0, 1'b1, 1'b0, 4'h0);
    step();
    chk("ovf set", 32'(bus.ovf[1]), 32'h1);
    drive(1'b0, 4'b0010, 16'h00B0, 1'b1, 1'b0, 4'b0010);
    step();
    chk("ovf set beats clr", 32'(bus.ovf[1]), 32'h1);
    drive(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0010);
    step();
    chk("ovf clr", 32'(bus.ovf[1]), 32'h0);
    drive(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'h0);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("hold out_valid", 32'(bus.out_valid), 32'h1);
      chk("hold out_data", 32'(bus.out_data), 32'h7);
      chk("hold out_chan", 32'(bus.out_chan), 32'h1);
    end
    drive(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0);
    step();
    chk("next grant data", 32'(bus.out_data), 32'h8);
    chk("next grant level", 32'(bus.level[1]), 32'h1);
    drive(1'b1, 4'h0, 16'h0, 1'b0, 1'b1, 4'h0);
    step();
    drive(1'b0, 4'b1001, 16'hC00A, 1'b0, 1'b1, 4'h0);
    step();
    drive(1'b0, 4'b1001, 16'hD00B, 1'b0, 1'b1, 4'h0);
    step();
    chk("disabled out_valid", 32'(bus.out_valid), 32'h0);
    chk("disabled level[0]", 32'(bus.level[0]), 32'h2);
    chk("disabled level[3]", 32'(bus.level[3]), 32'h2);
    drive(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("rr chan", 32'(bus.out_chan), (n % 2 == 0) ? 32'h0 : 32'h3);
      chk("rr data", 32'(bus.out_data), (n == 0) ? 32'hA : (n == 1) ? 32'hC : (n == 2) ? 32'hB : 32'hD);
    end
    drive(1'b0, 4'b1111, 16'h1234, 1'b1, 1'b0, 4'h0);
    for (int n = 0; n < 3; n++) step();
    chk("pre-reset out_valid", 32'(bus.out_valid), 32'h1);
    drive(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'h0);
    step();
    chk("mid reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid reset levels", 32'({bus.level[3], bus.level[2], bus.level[1], bus.level[0]}), 32'h0);
    chk("mid reset ovf", 32'({bus.ovf[3], bus.ovf[2], bus.ovf[1], bus.ovf[0]}), 32'h0);
    drive(1'b0, 4'b0010, 16'h0060, 1'b1, 1'b1, 4'h0);
    step();
    drive(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'h0);
    step();
    chk("post reset chan", 32'(bus.out_chan), 32'h1);
    chk("post reset data", 32'(bus.out_data), 32'h6);
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom % 150 == 0), 4'($urandom), 16'($urandom), 1'($urandom % 4 != 0),
            1'($urandom % 3 != 0), ($urandom % 6 == 0) ? 4'($urandom) : 4'h0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
